// File: rtl/reset_sequencer.sv
// Debounces a board reset button, then releases N reset domains in index order; shared countdown.
// Latency: domain k releases 2 + DEBOUNCE_CYCLES + (k+1)*STAGE_CYCLES edges after release; no backpressure.
module reset_sequencer #(
  parameter int N_DOMAINS       = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int STAGE_CYCLES    = 1000,
  parameter int CNT_W           = 17,
  parameter int STAGE_W         = ($clog2(N_DOMAINS) < 1) ? 1 : $clog2(N_DOMAINS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_btn,
  input  logic                 i_sw_req,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 sys_ready,
  output logic                 busy,
  output logic [STAGE_W-1:0]   stage
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    DEBOUNCE = 2'd1,
    STAGE    = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   DEB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STG_LOAD   = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_DOMAINS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 sys_ready_q, sys_ready_d;
  logic                 busy_q, busy_d;
  logic                 btn_meta_q, btn_meta_d;
  logic                 btn_s_q, btn_s_d;

  always_comb begin
    btn_meta_d  = i_btn;
    btn_s_d     = btn_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    rst_out_d   = rst_out_q;
    sys_ready_d = sys_ready_q;
    busy_d      = busy_q;

    // A press or a software request wins from any state, including mid-sequence.
    if (btn_s_q || i_sw_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      stage_d     = '0;
      rst_out_d   = '1;
      sys_ready_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = DEBOUNCE;
          cnt_d   = DEB_LOAD;
          busy_d  = 1'b1;
        end
        DEBOUNCE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = STAGE;
            cnt_d   = STG_LOAD;
            stage_d = '0;
          end
        end
        STAGE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            rst_out_d[stage_q] = 1'b0;
            if (stage_q == LAST_STAGE) begin
              state_d     = RUN;
              sys_ready_d = 1'b1;
              busy_d      = 1'b0;
            end else begin
              stage_d = stage_q + 1'b1;
              cnt_d   = STG_LOAD;
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // Synchroniser resets to "pressed" so no domain can leave reset before a real release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_meta_q  <= 1'b1;
      btn_s_q     <= 1'b1;
      state_q     <= HOLD;
      cnt_q       <= '0;
      stage_q     <= '0;
      rst_out_q   <= '1;
      sys_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      btn_meta_q  <= btn_meta_d;
      btn_s_q     <= btn_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      rst_out_q   <= rst_out_d;
      sys_ready_q <= sys_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign sys_ready = sys_ready_q;
  assign busy      = busy_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output changes are queued with their edge number
// and a negedge monitor pops one whenever rst_out, sys_ready or busy changes.
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int DEB = 8;
  localparam int STG = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         i_btn;
  logic         i_sw_req;
  logic [N-1:0] rst_out;
  logic         sys_ready;
  logic         busy;
  logic [1:0]   stage;

  reset_sequencer #(
    .N_DOMAINS(N), .DEBOUNCE_CYCLES(DEB), .STAGE_CYCLES(STG), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .i_btn(i_btn), .i_sw_req(i_sw_req),
    .rst_out(rst_out), .sys_ready(sys_ready), .busy(busy), .stage(stage)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
    logic       bsy;
    logic [1:0] stg;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  logic [5:0] prev_obs;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r, input logic rd, input logic b, input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.rst = r; e.rdy = rd; e.bsy = b; e.stg = s;
    exp_q.push_back(e);
  endtask

  // Abort: everything back in reset, idle.
  task automatic push_abort(input int c);
    push(c, 4'b1111, 1'b0, 1'b0, 2'd0);
  endtask

  // e0 = first edge sampling i_btn=0 with btn_s still 1; n = number of domain releases expected.
  task automatic push_seq(input int e0, input int n);
    push(e0 + 2, 4'b1111, 1'b0, 1'b1, 2'd0);
    if (n > 0) push(e0 + 14, 4'b1110, 1'b0, 1'b1, 2'd1);
    if (n > 1) push(e0 + 18, 4'b1100, 1'b0, 1'b1, 2'd2);
    if (n > 2) push(e0 + 22, 4'b1000, 1'b0, 1'b1, 2'd3);
    if (n > 3) push(e0 + 26, 4'b0000, 1'b1, 1'b0, 2'd3);
  endtask

  // Returns at the negedge before edge e, so inputs driven next are sampled at edge e.
  task automatic at_edge(input int e);
    while (cyc < e - 1) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (mon_en && ({rst_out, sys_ready, busy} !== prev_obs)) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_check++;
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d rst_out=%b sys_ready=%b busy=%b stage=%0d", cyc, rst_out, sys_ready, busy, stage);
      end else begin
        e = exp_q.pop_front();
        n_check++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL event_cycle got=%0d want=%0d (want rst_out=%b)", cyc, e.cyc, e.rst);
        end
        n_check++;
        if ({rst_out, sys_ready, busy, stage} !== {e.rst, e.rdy, e.bsy, e.stg}) begin
          n_fail++;
          $display("FAIL event_outputs cyc=%0d got rst_out=%b rdy=%b busy=%b stage=%0d want rst_out=%b rdy=%b busy=%b stage=%0d",
                   cyc, rst_out, sys_ready, busy, stage, e.rst, e.rdy, e.bsy, e.stg);
        end
      end
    end
    prev_obs = {rst_out, sys_ready, busy};
  end

  initial begin
    RST = 1'b1; i_btn = 1'b0; i_sw_req = 1'b0;

    // Power-up: reset values held while RST is asserted.
    repeat (3) begin
      @(negedge CLK);
      n_check++;
      if ({rst_out, sys_ready, busy, stage} !== {4'b1111, 1'b0, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got rst_out=%b rdy=%b busy=%b stage=%0d want 1111/0/0/0", cyc, rst_out, sys_ready, busy, stage);
      end
    end
    RST = 1'b0;
    push_seq(4, 4);
    mon_en = 1'b1;

    // Press while running, held, then clean release.
    at_edge(40); i_btn = 1'b1; push_abort(42);
    at_edge(50); i_btn = 1'b0; push_seq(50, 4);

    // Bounce during debounce restarts the full count.
    at_edge(90);  i_btn = 1'b1; push_abort(92);
    at_edge(100); i_btn = 1'b0; push_seq(100, 0);
    at_edge(105); i_btn = 1'b1; push_abort(107);
    at_edge(107); i_btn = 1'b0; push_seq(107, 4);

    // Software request from RUN, then again mid-stage with rst_out=1100.
    at_edge(140); i_sw_req = 1'b1; push_abort(140); push_seq(139, 2);
    at_edge(141); i_sw_req = 1'b0;
    at_edge(159); i_sw_req = 1'b1; push_abort(159); push_seq(158, 4);
    at_edge(160); i_sw_req = 1'b0;

    // RST mid-debounce.
    at_edge(190); i_sw_req = 1'b1; push_abort(190); push_seq(189, 0);
    at_edge(191); i_sw_req = 1'b0;
    at_edge(195); RST = 1'b1; push_abort(195); push_seq(196, 4);
    at_edge(196); RST = 1'b0;

    while (exp_q.size() != 0 && cyc < 400) @(negedge CLK);
    repeat (20) @(negedge CLK);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_check++;
      n_fail++;
      $display("FAIL missing_event want cyc=%0d rst_out=%b", e.cyc, e.rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
